// File: rtl/board_rst_seq_if.sv
// Board-side pins of the reset sequencer: raw button and PLL lock in,
// staggered per-domain resets, ready flag and button event out.
interface board_rst_seq_if #(
   parameter int N_RST = 2
);
   logic             btn_i;
   logic             pll_lock_i;
   logic [N_RST-1:0] rst_o;
   logic             ready_o;
   logic             btn_evt_o;

   modport master (
      output btn_i, pll_lock_i,
      input  rst_o, ready_o, btn_evt_o
   );

   modport slave (
      input  btn_i, pll_lock_i,
      output rst_o, ready_o, btn_evt_o
   );
endinterface

// File: rtl/board_rst_seq.sv
// Board reset sequencer: synchronises and debounces the reset button,
// qualifies on PLL lock, stretches a power-on reset and then releases the
// per-domain resets one after another (bit 0 first). A debounced press or
// a loss of lock drops every domain back into reset.
module board_rst_seq #(
   parameter int CLK_HZ         = 28_500_000,
   parameter int DEBOUNCE_MS    = 10,
   parameter int POR_CYCLES     = 1024,
   parameter int N_RST          = 2,
   parameter int STAGGER_CYCLES = 16,
   parameter bit BTN_ACTIVE_LOW = 1'b1
) (
   input logic            clk,
   input logic            rst,
   board_rst_seq_if.slave bus
);

   localparam int DB_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS;
   localparam int DB_W      = $clog2(DB_CYCLES + 1);
   localparam int POR_W     = $clog2(POR_CYCLES + 1);
   localparam int STG_W     = $clog2(STAGGER_CYCLES + 1);
   localparam int IDX_W     = $clog2(N_RST + 1);

   typedef enum logic [1:0] {HOLD, POR, REL, RUN} state_t;

   // The button is normalised before synchronising so that the cleared
   // synchroniser state means "not pressed" regardless of pin polarity.
   logic [1:0]       btn_sync;
   logic [1:0]       lock_sync;
   logic             pressed_s;
   logic             lock_s;

   logic             pressed_d;
   logic [DB_W-1:0]  db_cnt;
   logic             evt_q;

   state_t           state;
   logic [POR_W-1:0] por_cnt;
   logic [STG_W-1:0] stg_cnt;
   logic [IDX_W-1:0] idx;
   logic [N_RST-1:0] rst_q;
   logic             ready_q;
   logic             qual;

   assign pressed_s = btn_sync[1];
   assign lock_s    = lock_sync[1];
   assign qual      = lock_s & ~pressed_d;

   assign bus.rst_o     = rst_q;
   assign bus.ready_o   = ready_q;
   assign bus.btn_evt_o = evt_q;

   // Two-flop synchronisers for the asynchronous button and lock pins.
   always_ff @(posedge clk) begin
      if (rst) begin
         btn_sync  <= '0;
         lock_sync <= '0;
      end else begin
         btn_sync  <= {btn_sync[0], bus.btn_i ^ BTN_ACTIVE_LOW};
         lock_sync <= {lock_sync[0], bus.pll_lock_i};
      end
   end

   // Debounce: the stable state follows the input only after it has
   // differed for DB_CYCLES consecutive cycles; a press emits one pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         pressed_d <= 1'b0;
         db_cnt    <= '0;
         evt_q     <= 1'b0;
      end else begin
         evt_q <= 1'b0;
         if (pressed_s == pressed_d) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
            pressed_d <= pressed_s;
            db_cnt    <= '0;
            evt_q     <= pressed_s;
         end else begin
            db_cnt <= db_cnt + DB_W'(1);
         end
      end
   end

   // Sequencer: hold until qualified, stretch, then release domains one
   // per stagger period. Losing qualification outranks any release, and
   // released bits are only ever re-asserted all together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= HOLD;
         por_cnt <= '0;
         stg_cnt <= '0;
         idx     <= '0;
         rst_q   <= '1;
         ready_q <= 1'b0;
      end else if (state != HOLD && !qual) begin
         state   <= HOLD;
         por_cnt <= '0;
         stg_cnt <= '0;
         idx     <= '0;
         rst_q   <= '1;
         ready_q <= 1'b0;
      end else begin
         case (state)
            HOLD: begin
               if (qual) begin
                  state   <= POR;
                  por_cnt <= '0;
               end
            end
            POR: begin
               if (por_cnt == POR_W'(POR_CYCLES - 1)) begin
                  por_cnt <= '0;
                  rst_q   <= rst_q << 1;
                  if (N_RST == 1) begin
                     state   <= RUN;
                     ready_q <= 1'b1;
                  end else begin
                     state   <= REL;
                     idx     <= '0;
                     stg_cnt <= '0;
                  end
               end else begin
                  por_cnt <= por_cnt + POR_W'(1);
               end
            end
            REL: begin
               if (stg_cnt == STG_W'(STAGGER_CYCLES - 1)) begin
                  stg_cnt <= '0;
                  rst_q   <= rst_q << 1;
                  idx     <= idx + IDX_W'(1);
                  if (idx == IDX_W'(N_RST - 2)) begin
                     state   <= RUN;
                     ready_q <= 1'b1;
                  end
               end else begin
                  stg_cnt <= stg_cnt + STG_W'(1);
               end
            end
            RUN: begin
               ready_q <= 1'b1;
            end
            default: begin
               state <= HOLD;
               rst_q <= '1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_board_rst_seq.sv
// Bench for board_rst_seq: a three-domain instance and a single-domain,
// one-cycle-stretch instance share the same pins. Every cycle both are
// compared against a behavioural model that derives the release pattern
// arithmetically from the time elapsed since qualification.
module tb_board_rst_seq;

   localparam int DB   = 4;
   localparam int POR0 = 8;
   localparam int STG0 = 2;
   localparam int N0   = 3;
   localparam int POR1 = 1;
   localparam int N1   = 1;

   logic clk;
   logic rst;
   logic btn;
   logic lock;

   board_rst_seq_if #(.N_RST(N0)) bus ();
   board_rst_seq_if #(.N_RST(N1)) bus1 ();

   assign bus.btn_i       = btn;
   assign bus.pll_lock_i  = lock;
   assign bus1.btn_i      = btn;
   assign bus1.pll_lock_i = lock;

   board_rst_seq #(
      .CLK_HZ(1000), .DEBOUNCE_MS(4), .POR_CYCLES(POR0),
      .N_RST(N0), .STAGGER_CYCLES(STG0), .BTN_ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   board_rst_seq #(
      .CLK_HZ(1000), .DEBOUNCE_MS(4), .POR_CYCLES(POR1),
      .N_RST(N1), .STAGGER_CYCLES(1), .BTN_ACTIVE_LOW(1'b1)
   ) dut1 (
      .clk(clk), .rst(rst), .bus(bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int evt_cnt = 0;

   // Reference model state
   bit m_s1l, m_s2l, m_s1p, m_s2p;
   bit m_pd;
   int m_run;
   bit m_evt;
   bit m_hold [2] = '{1'b1, 1'b1};
   int m_k    [2] = '{0, 0};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      vectors++;
      assert (obs === req) else begin
         miscompares++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, req);
      end
   endtask

   // Number of domains released: none until the stretch has elapsed, then
   // one more every stagger period, capped at the domain count.
   function automatic int rel_cnt(input int d);
      int por, stg, n, r;
      por = (d == 0) ? POR0 : POR1;
      stg = (d == 0) ? STG0 : 1;
      n   = (d == 0) ? N0 : N1;
      if (m_hold[d] || m_k[d] < por) return 0;
      r = 1 + (m_k[d] - por) / stg;
      return (r > n) ? n : r;
   endfunction

   function automatic int rst_req(input int d);
      int n, r;
      n = (d == 0) ? N0 : N1;
      r = rel_cnt(d);
      return ((1 << n) - 1) & ~((1 << r) - 1);
   endfunction

   // Advance the model by one clock edge using the pin values at that edge.
   task automatic model_edge();
      bit qual;
      qual = m_s2l && !m_pd;
      if (rst) begin
         m_s1l = 0; m_s2l = 0; m_s1p = 0; m_s2p = 0;
         m_pd = 0; m_run = 0; m_evt = 0;
         for (int d = 0; d < 2; d++) begin
            m_hold[d] = 1'b1;
            m_k[d]    = 0;
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            if (m_hold[d]) begin
               if (qual) begin
                  m_hold[d] = 1'b0;
                  m_k[d]    = 0;
               end
            end else if (!qual) begin
               m_hold[d] = 1'b1;
            end else if (m_k[d] < 100000) begin
               m_k[d]++;
            end
         end
         m_evt = 1'b0;
         if (m_s2p != m_pd) begin
            m_run++;
            if (m_run == DB) begin
               m_pd  = m_s2p;
               m_run = 0;
               m_evt = m_s2p;
            end
         end else begin
            m_run = 0;
         end
         m_s2l = m_s1l; m_s1l = lock;
         m_s2p = m_s1p; m_s1p = !btn;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      if (bus.btn_evt_o === 1'b1) evt_cnt++;
      chk("rst_o",        32'(bus.rst_o),      32'(rst_req(0)));
      chk("ready_o",      32'(bus.ready_o),    32'(rel_cnt(0) == N0));
      chk("btn_evt_o",    32'(bus.btn_evt_o),  32'(m_evt));
      chk("rst_o_n1",     32'(bus1.rst_o),     32'(rst_req(1)));
      chk("ready_o_n1",   32'(bus1.ready_o),   32'(rel_cnt(1) == N1));
      chk("btn_evt_o_n1", 32'(bus1.btn_evt_o), 32'(m_evt));
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      rst = 1'b1; btn = 1'b1; lock = 1'b1;

      // Reset values
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("reset_rst_o",   32'(bus.rst_o),     32'b111);
         chk("reset_ready",   32'(bus.ready_o),   32'd0);
         chk("reset_evt",     32'(bus.btn_evt_o), 32'd0);
         chk("reset_rst_o1",  32'(bus1.rst_o),    32'd1);
      end

      // Nominal release schedule, L = 2 edges after rst drops
      rst = 1'b0;
      tick_n(4);
      chk("n1_released_L+2", 32'(bus1.rst_o),   32'd0);
      chk("n1_ready_L+2",    32'(bus1.ready_o), 32'd1);
      tick_n(6);
      chk("nom_before_rel0", 32'(bus.rst_o), 32'b111);
      tick_n(1);
      chk("nom_L+9",  32'(bus.rst_o), 32'b110);
      tick_n(2);
      chk("nom_L+11", 32'(bus.rst_o), 32'b100);
      tick_n(2);
      chk("nom_L+13", 32'(bus.rst_o), 32'b000);
      chk("nom_ready", 32'(bus.ready_o), 32'd1);

      // Short glitches: no event, no abort
      for (int g = 0; g < 2; g++) begin
         int len;
         len = (g == 0) ? 3 : int'($urandom_range(1, 3));
         tick_n(int'($urandom_range(1, 5)));
         evt_cnt = 0;
         btn = 1'b0;
         tick_n(len);
         btn = 1'b1;
         tick_n(8);
         chk("glitch_no_evt", 32'(evt_cnt),     32'd0);
         chk("glitch_ready",  32'(bus.ready_o), 32'd1);
      end

      // Debounced press: one event, reset one edge later, identical restart
      evt_cnt = 0;
      btn = 1'b0;
      tick_n(6);
      chk("press_evt",        32'(bus.btn_evt_o), 32'd1);
      chk("press_rst_o_same", 32'(bus.rst_o),     32'b000);
      btn = 1'b1;
      tick_n(1);
      chk("press_rst_o_next", 32'(bus.rst_o),   32'b111);
      chk("press_ready_next", 32'(bus.ready_o), 32'd0);
      tick_n(14);
      chk("repress_L+9",  32'(bus.rst_o), 32'b110);
      tick_n(2);
      chk("repress_L+11", 32'(bus.rst_o), 32'b100);
      tick_n(2);
      chk("repress_L+13", 32'(bus.rst_o), 32'b000);
      chk("repress_ready", 32'(bus.ready_o), 32'd1);
      chk("press_one_evt", 32'(evt_cnt), 32'd1);

      // Lock loss in RUN, then mid-release, then full restart
      lock = 1'b0;
      tick_n(2);
      chk("lockloss_run_2", 32'(bus.ready_o), 32'd1);
      tick_n(1);
      chk("lockloss_run_3", 32'(bus.rst_o),   32'b111);
      tick_n(int'($urandom_range(2, 6)));
      lock = 1'b1;
      tick_n(11);
      chk("relock_L+9", 32'(bus.rst_o), 32'b110);
      lock = 1'b0;
      tick_n(3);
      chk("lockloss_rel_rst", 32'(bus.rst_o),   32'b111);
      chk("lockloss_rel_rdy", 32'(bus.ready_o), 32'd0);
      tick_n(int'($urandom_range(2, 6)));
      lock = 1'b1;
      tick_n(11);
      chk("relock2_L+9",  32'(bus.rst_o), 32'b110);
      tick_n(2);
      chk("relock2_L+11", 32'(bus.rst_o), 32'b100);
      tick_n(2);
      chk("relock2_L+13", 32'(bus.rst_o), 32'b000);
      chk("relock2_ready", 32'(bus.ready_o), 32'd1);

      // rst during POR with lock held
      lock = 1'b0;
      tick_n(4);
      lock = 1'b1;
      tick_n(5);
      chk("in_por_rst_o", 32'(bus.rst_o), 32'b111);
      rst = 1'b1;
      tick_n(2);
      chk("rst_in_por_rst_o", 32'(bus.rst_o),   32'b111);
      chk("rst_in_por_ready", 32'(bus.ready_o), 32'd0);
      rst = 1'b0;
      tick_n(4);
      chk("rst_por_n1_L+2", 32'(bus1.rst_o), 32'd0);
      tick_n(6);
      chk("rst_por_L+8", 32'(bus.rst_o), 32'b111);
      tick_n(1);
      chk("rst_por_L+9", 32'(bus.rst_o), 32'b110);

      // Randomised mix of presses, lock drops and resets against the model
      for (int it = 0; it < 40; it++) begin
         case ($urandom_range(0, 3))
            0: tick_n(int'($urandom_range(1, 20)));
            1: begin
               btn = 1'b0;
               tick_n(int'($urandom_range(1, 8)));
               btn = 1'b1;
            end
            2: begin
               lock = 1'b0;
               tick_n(int'($urandom_range(1, 6)));
               lock = 1'b1;
            end
            default: begin
               rst = 1'b1;
               tick_n(int'($urandom_range(1, 2)));
               rst = 1'b0;
            end
         endcase
         tick_n(int'($urandom_range(1, 16)));
      end
      tick_n(30);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/board_rst_seq.md
# board_rst_seq

Parametrised reset sequencer sitting between the board pins (push-button, PLL lock) and the design core in every board top. It synchronises and debounces the reset button, qualifies on PLL lock, stretches a power-on reset, and releases `N_RST` synchronous active-high reset outputs one after another with a programmable stagger. Any debounced button press or loss of lock re-enters reset. This supports multi-block cores (e.g. UART front end before ALU) without ad-hoc `!BTN_N` wiring.

## Interface
- `CLK_HZ`, default 28_500_000: frequency of `clk`, in Hz.
- `DEBOUNCE_MS`, default 10: button debounce window. `DB_CYCLES = CLK_HZ/1000*DEBOUNCE_MS`, must be ≥1.
- `POR_CYCLES`, default 1024: reset stretch after qualification, ≥1.
- `N_RST`, default 2: number of reset outputs, ≥1.
- `STAGGER_CYCLES`, default 16: spacing between successive releases, ≥1.
- `BTN_ACTIVE_LOW`, default 1: 1 means a pressed button reads `btn_i=0`.

- `clk` in 1: single clock for all logic.
- `rst` in 1: synchronous, active-high reset.
- `btn_i` in 1: raw asynchronous button pin.
- `pll_lock_i` in 1: asynchronous PLL lock.
- `rst_o` out N_RST: per-domain synchronous active-high resets; bit 0 is released first.
- `ready_o` out 1: high once all `rst_o` bits have been released.
- `btn_evt_o` out 1: one-cycle pulse on each debounced press.

## Operation
- Sync: `btn_i` and `pll_lock_i` each pass through a 2-flop synchroniser, giving `btn_s` and `lock_s`. `btn_s` is normalised to `pressed_s` (1 = pressed) according to `BTN_ACTIVE_LOW`.
- Debounce: holds a stable state `pressed_d`.
  - Counter `db_cnt`, width `$clog2(DB_CYCLES+1)`, is cleared whenever `pressed_s == pressed_d`, and increments otherwise.
  - When `db_cnt` reaches `DB_CYCLES-1` while still differing, `pressed_d` flips and `db_cnt` clears.
  - `btn_evt_o` pulses on the cycle `pressed_d` goes 0→1. Releases generate no pulse.
- Qualification: `qual = lock_s & ~pressed_d`.
- FSM states:
  - `HOLD`: `rst_o` all 1s, `ready_o`=0. Goes to `POR` when `qual`=1.
  - `POR`: counter runs 0..`POR_CYCLES-1`. After the terminal count, goes to `REL` with `idx`=0 and `rst_o[0]` cleared.
  - `REL`: stagger counter runs 0..`STAGGER_CYCLES-1`. At each terminal count, `idx` increments and `rst_o[idx]` is cleared. When `idx` reaches `N_RST-1`, goes to `RUN`.
    - If `N_RST`=1: go from `POR` straight to `RUN`, clearing `rst_o[0]`.
  - `RUN`: `ready_o`=1, `rst_o` all 0s.
- Abort: in any state other than `HOLD`, `qual`=0 sends the FSM to `HOLD` on the next edge. This sets all `rst_o` and clears `ready_o`, `idx` and all counters. Abort takes priority over any same-cycle release.
- Released bits stay released until abort or `rst`; a bit is never re-asserted individually.
- Counter widths: `$clog2(max+1)`. Counters never wrap; they clear on state exit.

## Timing
- `rst`=1 at an edge gives, on that edge:
  - `rst_o` = all 1s, `ready_o`=0, `btn_evt_o`=0;
  - FSM = `HOLD`, `pressed_d`=0;
  - synchronisers = 0 (lock low, not pressed), all counters = 0.
- `rst` overrides everything, including mid-sequence and mid-debounce.
- Input to `lock_s`/`btn_s` latency is 2 cycles.
- Release schedule, with L = first cycle `qual`=1 while in `HOLD`:
  - FSM in `POR` at edge L+1;
  - `rst_o[0]`=0 at edge L+1+`POR_CYCLES`;
  - `rst_o[i]`=0 at edge L+1+`POR_CYCLES`+i·`STAGGER_CYCLES`;
  - `ready_o`=1 on the same edge as `rst_o[N_RST-1]` clears.
- Debounce press latency: a clean press at pin cycle P gives `pressed_d`=1 and `btn_evt_o`=1 at edge P+2+`DB_CYCLES`. `qual` falls the same cycle, and all `rst_o` are re-asserted one edge later.
- Button glitch shorter than `DB_CYCLES` cycles: no `pressed_d` change, no event, no abort.
- Lock loss in `RUN`: all `rst_o`=1 three edges after `pll_lock_i` falls (2 sync + 1).

## Test plan
Bench parameters: `CLK_HZ`=1000, `DEBOUNCE_MS`=4 (`DB_CYCLES`=4), `POR_CYCLES`=8, `N_RST`=3, `STAGGER_CYCLES`=2, `BTN_ACTIVE_LOW`=1.

- Reset values: `rst` high 3 cycles with lock=1 → during reset `rst_o`=3'b111, `ready_o`=0, `btn_evt_o`=0. After `rst` drops, the next checks apply.
- Nominal sequence: `btn_i`=1, lock=1, with L at the first qualified cycle → `rst_o`=3'b110 at L+9, 3'b100 at L+11, 3'b000 with `ready_o`=1 at L+13.
- Debounce:
  - a 3-cycle low pulse on `btn_i` in `RUN` → no `btn_evt_o`, `ready_o` stays 1;
  - a 6-cycle low pulse → exactly one `btn_evt_o` pulse, `rst_o`=3'b111 the next edge.
  - After release plus 4 stable cycles, the sequence restarts with identical timing.
- Lock loss mid-`REL` (after `rst_o`=3'b110) → `rst_o`=3'b111, `ready_o`=0 three edges after lock falls. Lock restored → full 13-cycle schedule repeats from a fresh L.
- `rst` asserted during `POR` with lock held → FSM back to `HOLD`. After release, `rst_o[0]` clears exactly L'+9 from the new qualification.
- `N_RST`=1, `POR_CYCLES`=1 variant → `rst_o`=0 and `ready_o`=1 at L+2.
